// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared definitions for the accumulator CPU fetch/sequencing
// unit. It holds the FSM state encoding, the opcode constants shared with the
// decoder, and the opcode legality function used by op_legal.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  // Opcodes with special meaning to the sequencer or decoder.
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_JMP  = 6'b110000;
  localparam logic [5:0] OP_BN   = 6'b110001;
  localparam logic [5:0] OP_BZ   = 6'b110010;
  localparam logic [5:0] OP_JACC = 6'b101100;
  localparam logic [5:0] OP_IN   = 6'b101000;
  localparam logic [5:0] OP_OUT  = 6'b101001;

  // Every opcode with a clear MSB (000000..011111) is an ALU/load/store
  // form; above that only a handful of control and I/O opcodes exist.
  function automatic logic is_legal_op(input logic [5:0] opcode);
    return (opcode[5] == 1'b0) ||
           (opcode inside {OP_IN, OP_OUT, OP_JACC, OP_JMP, OP_BN, OP_BZ, OP_HALT});
  endfunction

endpackage

// File: rtl/fetch_seq_op_legal.sv
// op_legal: combinational legality check of a 6-bit opcode.
// Ports:
//   opcode  in  6  opcode to classify
//   legal   out 1  1 when opcode is defined in the instruction set
module op_legal
  import fetch_seq_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       legal
);

  assign legal = is_legal_op(opcode);

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: instruction fetch and sequencing unit of the accumulator CPU.
// Fetches 16-bit words over a req/ack handshake, splits them into opcode and
// constant, presents them to the datapath with exec_valid/exec_done, then
// advances the PC (sequential or branch). Owns halt, illegal-opcode and
// fetch-timeout handling.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   run                        start fetching from IDLE
//   imem_req/addr/ack/rdata    instruction memory handshake
//   op, c_const, exec_valid    current instruction to decoder/datapath
//   exec_done, br_taken, br_target  retirement and branch result
//   pc                         current program counter
//   halted, illegal_op, fault  status (illegal_op and fault are sticky)
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter int              AW       = 10,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter int              TMO_CYC  = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  output logic [5:0]    op,
  output logic [9:0]    c_const,
  output logic          exec_valid,
  input  logic          exec_done,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic [AW-1:0] pc,
  output logic          halted,
  output logic          illegal_op,
  output logic          fault
);

  // The counter only has to hold 0..TMO_CYC-1: it holds the number of FETCH
  // cycles already completed, so reaching TMO_CYC-1 without an ack means the
  // current cycle is the last one allowed.
  localparam int            TW       = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam bit            TMO_EN   = (TMO_CYC > 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic          op_ok;

  op_legal u_op_legal (
    .opcode (op),
    .legal  (op_ok)
  );

  assign imem_addr = pc;

  // NOTE: all state and registered outputs live in one clocked block and are
  // updated with non-blocking assignments, so every branch reads the values
  // from before the edge and no ordering between assignments matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      op         <= OP_HALT;
      c_const    <= '0;
      tmo_cnt    <= '0;
      imem_req   <= 1'b0;
      exec_valid <= 1'b0;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
      fault      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (run) begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
            tmo_cnt  <= '0;
          end
        end

        ST_FETCH: begin
          // An ack in the last allowed cycle wins over the timeout.
          if (imem_ack) begin
            op         <= imem_rdata[15:10];
            c_const    <= imem_rdata[9:0];
            imem_req   <= 1'b0;
            exec_valid <= 1'b1;
            state      <= ST_EXEC;
          end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
            imem_req <= 1'b0;
            fault    <= 1'b1;
            halted   <= 1'b1;
            state    <= ST_FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end

        ST_EXEC: begin
          if (exec_done) begin
            exec_valid <= 1'b0;
            if (op == OP_HALT) begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end else begin
              // Undefined opcodes retire as NOPs; only the flag records them.
              if (!op_ok) illegal_op <= 1'b1;
              pc       <= br_taken ? br_target : pc + AW'(1);
              imem_req <= 1'b1;
              tmo_cnt  <= '0;
              state    <= ST_FETCH;
            end
          end
        end

        ST_HALT, ST_FAULT: begin
          // Terminal until reset.
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed self-checking bench for fetch_seq (TMO_CYC = 4).
module tb_fetch_seq;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [15:0]   imem_rdata;
  logic [5:0]    op;
  logic [9:0]    c_const;
  logic          exec_valid;
  logic          exec_done;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic [AW-1:0] pc;
  logic          halted;
  logic          illegal_op;
  logic          fault;

  int checks = 0;
  int passes = 0;

  fetch_seq #(.AW(AW), .RESET_PC('0), .TMO_CYC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .op         (op),
    .c_const    (c_const),
    .exec_valid (exec_valid),
    .exec_done  (exec_done),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .pc         (pc),
    .halted     (halted),
    .illegal_op (illegal_op),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From a FETCH cycle: ack the word at once, retire it in its first EXEC
  // cycle with the given branch result. Ends in the following cycle.
  task automatic run_instr(input logic [15:0] word, input logic taken, input logic [AW-1:0] target);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    check("exec_valid_in_exec", 32'(exec_valid), 32'h1);
    exec_done  = 1'b1;
    br_taken   = taken;
    br_target  = target;
    tick();
    exec_done  = 1'b0;
    br_taken   = 1'b0;
    br_target  = '0;
  endtask

  task automatic do_reset_and_run();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  initial begin
    int req_seen;
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    exec_done = 1'b0; br_taken = 1'b0; br_target = '0;
    tick();
    tick();

    // Reset values
    check("rst_imem_req",   32'(imem_req),   32'h0);
    check("rst_exec_valid", 32'(exec_valid), 32'h0);
    check("rst_halted",     32'(halted),     32'h0);
    check("rst_illegal",    32'(illegal_op), 32'h0);
    check("rst_fault",      32'(fault),      32'h0);
    check("rst_pc",         32'(pc),         32'h0);
    check("rst_op",         32'(op),         32'h3f);
    check("rst_c_const",    32'(c_const),    32'h0);

    rst_n = 1'b1;
    tick();
    check("idle_no_req", 32'(imem_req), 32'h0);

    // Run pulse, immediate ack of 16'h0405, done in first EXEC cycle
    run = 1'b1;
    tick();
    run = 1'b0;
    check("fetch_req",  32'(imem_req),  32'h1);
    check("fetch_addr", 32'(imem_addr), 32'h0);
    imem_ack = 1'b1; imem_rdata = 16'h0405;
    tick();
    imem_ack = 1'b0;
    check("exec_op",     32'(op),         32'h01);
    check("exec_c",      32'(c_const),    32'h005);
    check("exec_valid",  32'(exec_valid), 32'h1);
    check("exec_req_lo", 32'(imem_req),   32'h0);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("next_addr_1",   32'(imem_addr),  32'h1);
    check("next_req",      32'(imem_req),   32'h1);
    check("valid_dropped", 32'(exec_valid), 32'h0);

    // Advance to pc=3, then branch taken / not taken
    run_instr(16'h0000, 1'b0, '0);
    run_instr(16'h0000, 1'b0, '0);
    check("pc_3", 32'(pc), 32'h3);
    run_instr(16'hC000, 1'b1, 10'h120);
    check("br_taken_addr", 32'(imem_addr), 32'h120);
    run_instr(16'hC000, 1'b1, 10'h003);
    check("br_back_3", 32'(imem_addr), 32'h3);
    run_instr(16'h0000, 1'b0, 10'h155);
    check("br_not_taken_4", 32'(imem_addr), 32'h4);

    // Wrap at 3FF
    run_instr(16'hC000, 1'b1, 10'h3FF);
    check("pc_3ff", 32'(pc), 32'h3FF);
    run_instr(16'h0000, 1'b0, '0);
    check("wrap_addr_0", 32'(imem_addr), 32'h0);

    // Legal boundary opcodes must not flag; 100000 must, stickily
    run_instr({6'b011111, 10'h0}, 1'b0, '0);
    run_instr({6'b110010, 10'h0}, 1'b0, '0);
    run_instr({6'b101100, 10'h0}, 1'b0, '0);
    check("legal_no_flag", 32'(illegal_op), 32'h0);
    check("pc_after_legal", 32'(pc), 32'h3);
    run_instr({6'b100000, 10'h0}, 1'b0, '0);
    check("illegal_set",     32'(illegal_op), 32'h1);
    check("illegal_pc_inc",  32'(pc),         32'h4);
    check("illegal_fetches", 32'(imem_req),   32'h1);
    run_instr(16'h0000, 1'b0, '0);
    check("illegal_sticky", 32'(illegal_op), 32'h1);
    check("pc_5",           32'(pc),         32'h5);

    // Ack in FETCH cycle 4 is accepted (now in FETCH cycle 1)
    tick(); tick(); tick();
    check("tmo_c4_no_fault", 32'(fault), 32'h0);
    imem_ack = 1'b1; imem_rdata = 16'h0000;
    tick();
    imem_ack = 1'b0;
    check("tmo_c4_exec", 32'(exec_valid), 32'h1);
    check("tmo_c4_fault", 32'(fault),     32'h0);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("pc_6", 32'(pc), 32'h6);

    // Halt opcode
    imem_ack = 1'b1; imem_rdata = 16'hFC00;
    tick();
    imem_ack = 1'b0;
    check("halt_exec_valid", 32'(exec_valid), 32'h1);
    check("halt_op",         32'(op),         32'h3f);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("halted",          32'(halted),     32'h1);
    check("halt_valid_lo",   32'(exec_valid), 32'h0);
    check("halt_pc_same",    32'(pc),         32'h6);
    req_seen = 0;
    for (int i = 0; i < 100; i++) begin
      run      = i[0];
      imem_ack = i[1];
      tick();
      if (imem_req !== 1'b0 || halted !== 1'b1) req_seen++;
    end
    run = 1'b0; imem_ack = 1'b0;
    check("halt_100_quiet", 32'(req_seen), 32'h0);

    // Reset mid-FETCH drops imem_req asynchronously
    do_reset_and_run();
    check("fetch_again", 32'(imem_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_fetch_req", 32'(imem_req), 32'h0);

    // Timeout: no ack for 4 cycles -> FAULT in cycle 5
    do_reset_and_run();
    tick(); tick(); tick();
    check("tmo_c4_req",   32'(imem_req), 32'h1);
    check("tmo_c4_clean", 32'(fault),    32'h0);
    tick();
    check("tmo_fault",  32'(fault),    32'h1);
    check("tmo_halted", 32'(halted),   32'h1);
    check("tmo_req_lo", 32'(imem_req), 32'h0);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("fault_stays", 32'(exec_valid), 32'h0);

    // Reset mid-EXEC returns everything to reset values immediately
    do_reset_and_run();
    run_instr({6'b100000, 10'h0}, 1'b0, '0);
    imem_ack = 1'b1; imem_rdata = 16'h0405;
    tick();
    imem_ack = 1'b0;
    check("pre_rst_valid", 32'(exec_valid), 32'h1);
    check("pre_rst_pc",    32'(pc),         32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_exec_valid",   32'(exec_valid), 32'h0);
    check("mid_exec_pc",      32'(pc),         32'h0);
    check("mid_exec_op",      32'(op),         32'h3f);
    check("mid_exec_c",       32'(c_const),    32'h0);
    check("mid_exec_illegal", 32'(illegal_op), 32'h0);
    check("mid_exec_req",     32'(imem_req),   32'h0);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
